// File: rtl/fx_arb.sv
// fx_arb: round-robin arbiter/sequencer sharing the fx register bus between NUM_M masters.
// Optional FX_ARB_LOCK_EN: a winner holding m_lock keeps the round-robin pointer for its next request.
module fx_arb #(
  parameter int NUM_M = 2
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [NUM_M-1:0]     m_req,
  input  logic [NUM_M-1:0]     m_we,
  input  logic [NUM_M*22-1:0]  m_addr,
  input  logic [NUM_M*8-1:0]   m_wdata,
  input  logic [NUM_M-1:0]     m_lock,
  output logic [NUM_M-1:0]     m_gnt,
  output logic [NUM_M-1:0]     m_rvalid,
  output logic [7:0]           m_rdata,
  output logic                 fx_wr,
  output logic                 fx_rd,
  output logic [21:0]          fx_waddr,
  output logic [21:0]          fx_raddr,
  output logic [7:0]           fx_data,
  input  logic [7:0]           fx_q
);

  localparam int IW = $clog2(NUM_M);

  typedef enum logic [1:0] {IDLE, ISSUE, RCAP} state_e;

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [7:0]  wdata;
  } xact_t;

  state_e                state_q;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         win_q;
  logic                  we_q;
  logic [NUM_M-1:0]      m_gnt_q;
  logic [NUM_M-1:0]      m_rvalid_q;
  logic [7:0]            m_rdata_q;
  logic                  fx_wr_q;
  logic                  fx_rd_q;
  logic [21:0]           fx_waddr_q;
  logic [21:0]           fx_raddr_q;
  logic [7:0]            fx_data_q;

  xact_t [NUM_M-1:0]     mx;
  logic [IW-1:0]         win_d;
  logic                  found_d;
  logic [IW-1:0]         ptr_inc;
  logic                  lock_hold;

  for (genvar g = 0; g < NUM_M; g++) begin : g_unpack
    assign mx[g] = '{we: m_we[g], addr: m_addr[22*g +: 22], wdata: m_wdata[8*g +: 8]};
  end

  // First requester at or after ptr_q, wrapping modulo NUM_M.
  always_comb begin
    logic [IW-1:0] cand;
    win_d   = ptr_q;
    found_d = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_M; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_M);
      if (!found_d && m_req[cand]) begin
        found_d = 1'b1;
        win_d   = cand;
      end
    end
  end

  assign ptr_inc = (win_q == IW'(NUM_M - 1)) ? '0 : win_q + 1'b1;

`ifdef FX_ARB_LOCK_EN
  assign lock_hold = m_lock[win_q];
`else
  logic unused_lock;
  assign unused_lock = ^m_lock;
  assign lock_hold   = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      we_q       <= 1'b0;
      m_gnt_q    <= '0;
      m_rvalid_q <= '0;
      m_rdata_q  <= '0;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      fx_waddr_q <= '0;
      fx_raddr_q <= '0;
      fx_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          m_rvalid_q <= '0;
          if (found_d) begin
            win_q   <= win_d;
            we_q    <= mx[win_d].we;
            m_gnt_q <= NUM_M'(1) << win_d;
            if (mx[win_d].we) begin
              fx_wr_q    <= 1'b1;
              fx_waddr_q <= mx[win_d].addr;
              fx_data_q  <= mx[win_d].wdata;
            end else begin
              fx_rd_q    <= 1'b1;
              fx_raddr_q <= mx[win_d].addr;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // Bus returns to all-zero so no slave decodes a stray access.
          m_gnt_q    <= '0;
          m_rvalid_q <= '0;
          fx_wr_q    <= 1'b0;
          fx_rd_q    <= 1'b0;
          fx_waddr_q <= '0;
          fx_raddr_q <= '0;
          fx_data_q  <= '0;
          ptr_q      <= lock_hold ? win_q : ptr_inc;
          state_q    <= we_q ? IDLE : RCAP;
        end
        RCAP: begin
          m_rdata_q  <= fx_q;
          m_rvalid_q <= NUM_M'(1) << win_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_gnt    = m_gnt_q;
  assign m_rvalid = m_rvalid_q;
  assign m_rdata  = m_rdata_q;
  assign fx_wr    = fx_wr_q;
  assign fx_rd    = fx_rd_q;
  assign fx_waddr = fx_waddr_q;
  assign fx_raddr = fx_raddr_q;
  assign fx_data  = fx_data_q;

endmodule

// File: tb/tb_fx_arb.sv
// Self-checking bench for fx_arb: per-master drivers, a device-1 register slave, and a scoreboard
// of expected bus transactions and read returns.
module tb_fx_arb;
  localparam int NM = 2;

  logic              clk_sys = 1'b0;
  logic              rst_n   = 1'b0;
  logic [NM-1:0]     m_req   = '0;
  logic [NM-1:0]     m_we    = '0;
  logic [NM*22-1:0]  m_addr  = '0;
  logic [NM*8-1:0]   m_wdata = '0;
  logic [NM-1:0]     m_lock  = '0;
  logic [NM-1:0]     m_gnt;
  logic [NM-1:0]     m_rvalid;
  logic [7:0]        m_rdata;
  logic              fx_wr;
  logic              fx_rd;
  logic [21:0]       fx_waddr;
  logic [21:0]       fx_raddr;
  logic [7:0]        fx_data;
  logic [7:0]        fx_q;

  fx_arb #(.NUM_M(NM)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_lock(m_lock), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .fx_wr(fx_wr), .fx_rd(fx_rd), .fx_waddr(fx_waddr), .fx_raddr(fx_raddr), .fx_data(fx_data),
    .fx_q(fx_q)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          we;
    logic [21:0] addr;
    logic [7:0]  d;     // write data, or expected read data
    bit          lock;
  } op_t;
  typedef struct { int m; logic [7:0] d; int c; } rx_t;
  typedef struct { int m; int c; } g_t;

  op_t  mq   [NM][$];
  op_t  expq [NM][$];
  rx_t  rexp [$];
  g_t   glog [$];
  bit   active [NM];
  int   pres_cyc [NM];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   rv_cnt = 0;
  logic [7:0] last_rdata = '0;
  logic prev_strobe = 1'b0;

  bit [7:0] emem [256];
  bit       ewr  [256];

  // Device-1 slave: cells read back as (addr+1) until written; stored XOR-encoded so zero-init works.
  bit [7:0] smem [256];
  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) fx_q <= '0;
    else begin
      fx_q <= (fx_rd && fx_raddr[21:16] == 6'h01) ? (smem[fx_raddr[7:0]] ^ (fx_raddr[7:0] + 8'd1)) : 8'h00;
      if (fx_wr && fx_waddr[21:16] == 6'h01) smem[fx_waddr[7:0]] <= fx_data ^ (fx_waddr[7:0] + 8'd1);
    end
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(string tag, logic [95:0] got, logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(logic [21:0] a);
    if (a[21:16] != 6'h01) return 8'h00;
    return ewr[a[7:0]] ? emem[a[7:0]] : a[7:0] + 8'd1;
  endfunction

  task automatic q_wr(int m, logic [21:0] a, logic [7:0] d, bit lk = 1'b0);
    op_t o;
    o.we = 1'b1; o.addr = a; o.d = d; o.lock = lk;
    mq[m].push_back(o);
    if (a[21:16] == 6'h01) begin emem[a[7:0]] = d; ewr[a[7:0]] = 1'b1; end
  endtask

  task automatic q_rd(int m, logic [21:0] a);
    op_t o;
    o.we = 1'b0; o.addr = a; o.d = exp_rd(a); o.lock = 1'b0;
    mq[m].push_back(o);
  endtask

  task automatic drv_step();
    op_t o;
    if (!rst_n) begin
      for (int i = 0; i < NM; i++) begin
        mq[i].delete(); expq[i].delete(); active[i] = 1'b0;
        m_req[i] = 1'b0; m_lock[i] = 1'b0; m_we[i] = 1'b0;
      end
      return;
    end
    for (int i = 0; i < NM; i++) begin
      if (active[i] && m_gnt[i]) begin
        active[i] = 1'b0; m_req[i] = 1'b0; m_lock[i] = 1'b0; m_we[i] = 1'b0;
        m_addr[22*i +: 22] = '0; m_wdata[8*i +: 8] = '0;
      end
      if (!active[i] && mq[i].size() > 0) begin
        o = mq[i].pop_front();
        m_req[i] = 1'b1; m_we[i] = o.we; m_lock[i] = o.lock;
        m_addr[22*i +: 22] = o.addr;
        m_wdata[8*i +: 8]  = o.we ? o.d : 8'h00;
        expq[i].push_back(o);
        active[i] = 1'b1;
        pres_cyc[i] = cyc;
      end
    end
  endtask

  task automatic mon_step();
    op_t  e;
    rx_t  r;
    int   m;
    logic strobe;
    if (!rst_n) begin rexp.delete(); last_rdata = '0; prev_strobe = 1'b0; return; end
    strobe = fx_wr | fx_rd;
    chk("wr_rd_excl", 96'(fx_wr & fx_rd), 96'(0));
    if (strobe) begin
      chk("strobe_gap", 96'(prev_strobe), 96'(0));
      chk("gnt_onehot", 96'($onehot(m_gnt)), 96'(1));
      m = -1;
      for (int i = 0; i < NM; i++) if (m_gnt[i] && m < 0) m = i;
      if (m >= 0) begin
        glog.push_back('{m, cyc});
        if (expq[m].size() == 0) chk("unexp_gnt", 96'(m_gnt), 96'(0));
        else begin
          e = expq[m].pop_front();
          chk("dir", 96'(fx_wr), 96'(e.we));
          if (e.we) begin
            chk("waddr", 96'(fx_waddr), 96'(e.addr));
            chk("wdata", 96'(fx_data), 96'(e.d));
          end else begin
            chk("raddr", 96'(fx_raddr), 96'(e.addr));
            rexp.push_back('{m, e.d, cyc});
          end
        end
      end
    end else chk("idle_bus", 96'({m_gnt, fx_waddr, fx_raddr, fx_data}), 96'(0));
    if (|m_rvalid) begin
      if (rexp.size() == 0) chk("unexp_rvalid", 96'(m_rvalid), 96'(0));
      else begin
        r = rexp.pop_front();
        chk("rvalid_who", 96'(m_rvalid), 96'(NM'(1) << r.m));
        chk("rdata", 96'(m_rdata), 96'(r.d));
        chk("rvalid_lat", 96'(cyc - r.c), 96'(2));
        last_rdata = r.d;
      end
      rv_cnt++;
    end else chk("rdata_hold", 96'(m_rdata), 96'(last_rdata));
    prev_strobe = strobe;
  endtask

  always @(negedge clk_sys) drv_step();
  always @(negedge clk_sys) mon_step();

  function automatic bit all_done();
    for (int i = 0; i < NM; i++)
      if (mq[i].size() != 0 || expq[i].size() != 0 || active[i]) return 1'b0;
    return rexp.size() == 0 && !fx_wr && !fx_rd;
  endfunction

  task automatic wait_done(string tag, int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk_sys); #1;
      ok = all_done();
    end
    if (!ok) chk(tag, 96'(0), 96'(1));
  endtask

  function automatic int glog_m(int i);
    return (i < glog.size()) ? glog[i].m : -1;
  endfunction
  function automatic int glog_c(int i);
    return (i < glog.size()) ? glog[i].c : -1;
  endfunction

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_outs", 96'({m_gnt, m_rvalid, m_rdata, fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data}), 96'(0));
    repeat (2) @(negedge clk_sys);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk_sys); #2;
    reset_now();
  endtask

  initial begin
    int base, rv0;
    repeat (3) @(negedge clk_sys);
    #1;
    chk("por_outs", 96'({m_gnt, m_rvalid, m_rdata, fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data}), 96'(0));
    rst_n = 1'b1;

    // Single write: grant one cycle after the request is seen.
    base = glog.size();
    q_wr(0, 22'h010080, 8'h5A);
    wait_done("t1_timeout", 20);
    chk("t1_gnt_m", 96'(glog_m(base)), 96'(0));
    chk("t1_lat", 96'(glog_c(base) - pres_cyc[0]), 96'(1));

    // Single read of a fresh register: slave returns 0x01.
    base = glog.size(); rv0 = rv_cnt;
    q_rd(1, 22'h010000);
    wait_done("t2_timeout", 20);
    chk("t2_gnt_m", 96'(glog_m(base)), 96'(1));
    chk("t2_lat", 96'(glog_c(base) - pres_cyc[1]), 96'(1));
    chk("t2_rvcnt", 96'(rv_cnt - rv0), 96'(1));

    // Continuous contention from reset: strict alternation, one write per 2 cycles.
    do_reset();
    base = glog.size();
    q_wr(0, 22'h010010, 8'hAA); q_wr(0, 22'h010011, 8'hBB);
    q_wr(1, 22'h010020, 8'hCC); q_wr(1, 22'h010021, 8'hDD);
    wait_done("t3_timeout", 40);
    for (int j = 0; j < 4; j++) chk("t3_order", 96'(glog_m(base + j)), 96'(j % 2));
    for (int j = 0; j < 3; j++) chk("t3_spacing", 96'(glog_c(base + j + 1) - glog_c(base + j)), 96'(2));

    // Read back across masters, then unmapped device accesses.
    q_rd(1, 22'h010011); q_rd(0, 22'h010021);
    wait_done("t4_timeout", 40);
    q_wr(0, 22'h3F0080, 8'hEE); q_rd(0, 22'h3F0000); q_rd(0, 22'h010080);
    wait_done("t5_timeout", 40);

    // Reset during RCAP of a read: no rvalid, pointer back to master 0.
    base = glog.size(); rv0 = rv_cnt;
    q_rd(0, 22'h010001);
    for (int n = 0; n < 20 && glog.size() == base; n++) begin @(negedge clk_sys); #1; end
    if (glog.size() == base) chk("t6_gnt_timeout", 96'(0), 96'(1));
    @(posedge clk_sys); #2;
    reset_now();
    repeat (4) @(negedge clk_sys);
    #1;
    chk("t6_no_rvalid", 96'(rv_cnt - rv0), 96'(0));
    base = glog.size();
    q_wr(1, 22'h010060, 8'h61); q_wr(0, 22'h010061, 8'h62);
    wait_done("t6_timeout", 30);
    chk("t6_ptr0", 96'(glog_m(base)), 96'(0));
    chk("t6_second", 96'(glog_m(base + 1)), 96'(1));

    // Locked byte pair from master 0 against a competing master 1.
    do_reset();
    base = glog.size();
    q_wr(0, 22'h010040, 8'h11, 1'b1); q_wr(0, 22'h010041, 8'h22, 1'b1);
    q_wr(1, 22'h010050, 8'h33);
    wait_done("t7_timeout", 40);
    chk("t7_g0", 96'(glog_m(base)), 96'(0));
`ifdef FX_ARB_LOCK_EN
    chk("t7_g1", 96'(glog_m(base + 1)), 96'(0));
    chk("t7_g2", 96'(glog_m(base + 2)), 96'(1));
`else
    chk("t7_g1", 96'(glog_m(base + 1)), 96'(1));
    chk("t7_g2", 96'(glog_m(base + 2)), 96'(0));
`endif
    q_rd(1, 22'h010041);
    wait_done("t8_timeout", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
